// File: rtl/frame_buffer_arbiter_if.sv
// frame_buffer_arbiter_if: CPU, display and RAM bus signals of the frame buffer arbiter
interface frame_buffer_arbiter_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 12
);
  logic start, cpu_req, cpu_we, cpu_gnt, cpu_rvalid, disp_req, disp_rvalid, disp_miss, ram_we, done;
  logic [ADDR_WIDTH-1:0] cpu_addr, disp_addr, ram_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata, cpu_rdata, disp_rdata, ram_wdata, ram_rdata;
  logic [1:0] phase;
  modport master (
    output start, cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, ram_rdata,
    input cpu_gnt, cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata, disp_miss, ram_addr, ram_we,
    ram_wdata, phase, done
  );
  modport slave (
    input start, cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, ram_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata, disp_miss, ram_addr, ram_we,
    ram_wdata, phase, done
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: IDLE/RUN/SHOW sequencer and single-port image RAM arbiter (display vs CPU)
module frame_buffer_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 12,
  parameter int PIXEL_COUNT = 307200,
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic reset,
  frame_buffer_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, SHOW = 2'b10} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic cpu_gnt, disp_gnt, cpu_rd_q, disp_rd_q, last_wr;
  logic [DATA_WIDTH-1:0] cpu_hold, disp_hold;
  // Outside RUN the display has priority until the CPU has been starved MAX_WAIT cycles
  assign cpu_gnt = bus.cpu_req && (state == RUN || !bus.disp_req || wait_cnt == WAIT_MAX);
  assign disp_gnt = bus.disp_req && !cpu_gnt;
  assign last_wr = cpu_gnt && bus.cpu_we && bus.cpu_addr == LAST_ADDR;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == RUN) ? (last_wr ? SHOW : RUN) : (bus.start ? RUN : state);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      cpu_rd_q <= 1'b0;
      disp_rd_q <= 1'b0;
      cpu_hold <= '0;
      disp_hold <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= (bus.cpu_req && !cpu_gnt) ? ((wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1) : '0;
      cpu_rd_q <= cpu_gnt && !bus.cpu_we;
      disp_rd_q <= disp_gnt;
      if (cpu_rd_q) cpu_hold <= bus.ram_rdata;
      if (disp_rd_q) disp_hold <= bus.ram_rdata;
    end
  // RAM data arrives the cycle after the grant; the hold regs keep it afterwards
  assign bus.cpu_gnt = cpu_gnt;
  assign bus.disp_miss = bus.disp_req && cpu_gnt;
  assign bus.ram_addr = cpu_gnt ? bus.cpu_addr : bus.disp_addr;
  assign bus.ram_we = cpu_gnt && bus.cpu_we;
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.cpu_rvalid = cpu_rd_q;
  assign bus.cpu_rdata = cpu_rd_q ? bus.ram_rdata : cpu_hold;
  assign bus.disp_rvalid = disp_rd_q;
  assign bus.disp_rdata = disp_rd_q ? bus.ram_rdata : disp_hold;
  assign bus.phase = state;
  assign bus.done = state == SHOW;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed stimulus with a per-cycle behavioural model of the arbiter
module tb_frame_buffer_arbiter;
  localparam int AW = 19, DW = 12, PC = 307200, MW = 15;
  localparam logic [AW-1:0] LAST = AW'(PC - 1);
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0, errors = 0;
  frame_buffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  frame_buffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIXEL_COUNT(PC), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] pat(int a);
    return DW'(a) ^ 12'h3C3;
  endfunction
  // Environment RAM with 1-cycle synchronous read, and the model's own picture of its contents
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] mdl [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) begin
    ram[i] = pat(i);
    mdl[i] = pat(i);
  end
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model state: phase 0/1/2, starvation count, pending read results per requester
  int m_phase = 0, m_wait = 0;
  bit m_cpu_pend = 1'b0, m_disp_pend = 1'b0;
  logic [DW-1:0] m_cpu_val = '0, m_disp_val = '0, m_cpu_hold = '0, m_disp_hold = '0;
  // 0 = nobody, 1 = CPU, 2 = display
  function automatic int owner();
    if (m_phase == 1) return bus.cpu_req ? 1 : (bus.disp_req ? 2 : 0);
    if (bus.disp_req && !(bus.cpu_req && m_wait == MW)) return 2;
    return bus.cpu_req ? 1 : 0;
  endfunction
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_phase <= 0;
      m_wait <= 0;
      m_cpu_pend <= 1'b0;
      m_disp_pend <= 1'b0;
      m_cpu_hold <= '0;
      m_disp_hold <= '0;
    end else begin
      if (m_cpu_pend) m_cpu_hold <= m_cpu_val;
      if (m_disp_pend) m_disp_hold <= m_disp_val;
      m_cpu_pend <= owner() == 1 && !bus.cpu_we;
      m_cpu_val <= mdl[bus.cpu_addr];
      m_disp_pend <= owner() == 2;
      m_disp_val <= mdl[bus.disp_addr];
      if (owner() == 1 && bus.cpu_we) mdl[bus.cpu_addr] <= bus.cpu_wdata;
      m_wait <= (bus.cpu_req && owner() != 1) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
      if (m_phase == 1) begin
        if (owner() == 1 && bus.cpu_we && bus.cpu_addr == LAST) m_phase <= 2;
      end else if (bus.start) m_phase <= 1;
    end
  always @(negedge clk) begin
    #2;
    chk("cpu_gnt", bus.cpu_gnt, owner() == 1);
    chk("disp_miss", bus.disp_miss, bus.disp_req && owner() != 2);
    chk("ram_addr", bus.ram_addr, (owner() == 1) ? bus.cpu_addr : bus.disp_addr);
    chk("ram_we", bus.ram_we, owner() == 1 && bus.cpu_we);
    if (bus.ram_we) chk("ram_wdata", bus.ram_wdata, bus.cpu_wdata);
    chk("cpu_rvalid", bus.cpu_rvalid, m_cpu_pend);
    chk("cpu_rdata", bus.cpu_rdata, m_cpu_pend ? m_cpu_val : m_cpu_hold);
    chk("disp_rvalid", bus.disp_rvalid, m_disp_pend);
    chk("disp_rdata", bus.disp_rdata, m_disp_pend ? m_disp_val : m_disp_hold);
    chk("phase", bus.phase, m_phase);
    chk("done", bus.done, m_phase == 2);
  end
  task automatic drive(bit st, bit cr, bit cw, int ca, int cd, bit dr, int da);
    @(negedge clk);
    bus.start = st;
    bus.cpu_req = cr;
    bus.cpu_we = cw;
    bus.cpu_addr = AW'(ca);
    bus.cpu_wdata = DW'(cd);
    bus.disp_req = dr;
    bus.disp_addr = AW'(da);
    #3;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.start = 0; bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.disp_req = 0; bus.disp_addr = '0;
    idle();
    idle();
    chk("rst_phase", bus.phase, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 5);
    chk("t1_ram_addr", bus.ram_addr, 5);
    chk("t1_phase", bus.phase, 0);
    idle();
    chk("t1_disp_rvalid", bus.disp_rvalid, 1);
    chk("t1_disp_rdata", bus.disp_rdata, 12'h3C6);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 0, 20, 0, 1, 9);
      chk("starve_gnt", bus.cpu_gnt, i == 16);
      if (i == 16) chk("starve_miss", bus.disp_miss, 1);
    end
    drive(0, 1, 0, 20, 0, 1, 9);
    chk("wait_cleared", bus.cpu_gnt, 0);
    chk("starve_rvalid", bus.cpu_rvalid, 1);
    chk("starve_rdata", bus.cpu_rdata, 12'h3D7);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("pre_run_phase", bus.phase, 0);
    idle();
    chk("run_phase", bus.phase, 1);
    drive(0, 1, 1, 100, 'hABC, 1, 3);
    chk("run_wr_gnt", bus.cpu_gnt, 1);
    chk("run_wr_we", bus.ram_we, 1);
    chk("run_wr_miss", bus.disp_miss, 1);
    chk("run_wr_addr", bus.ram_addr, 100);
    drive(1, 0, 0, 0, 0, 1, 100);
    idle();
    chk("start_ignored", bus.phase, 1);
    chk("rd100_rvalid", bus.disp_rvalid, 1);
    chk("rd100_rdata", bus.disp_rdata, 12'hABC);
    drive(0, 1, 0, 7, 0, 0, 0);
    drive(0, 1, 1, 8, 'h123, 0, 0);
    chk("b2b_rvalid", bus.cpu_rvalid, 1);
    chk("b2b_rdata", bus.cpu_rdata, 12'h3C4);
    idle();
    chk("b2b_no_rvalid", bus.cpu_rvalid, 0);
    drive(0, 1, 1, PC, 'h111, 0, 0);
    drive(0, 1, 0, PC - 1, 0, 0, 0);
    idle();
    chk("beyond_last_phase", bus.phase, 1);
    chk("last_rd_rdata", bus.cpu_rdata, 12'hC3C);
    drive(1, 1, 1, PC - 1, 'h5E5, 0, 0);
    chk("last_wr_phase", bus.phase, 1);
    drive(0, 0, 0, 0, 0, 1, PC - 1);
    chk("show_phase", bus.phase, 2);
    chk("show_done", bus.done, 1);
    idle();
    chk("show_rdata", bus.disp_rdata, 12'h5E5);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 50, 'h777, 1, 60);
      chk("show_starve_gnt", bus.cpu_gnt, 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rerun_phase", bus.phase, 1);
    drive(0, 1, 0, 7, 0, 0, 0);
    chk("abort_gnt", bus.cpu_gnt, 1);
    reset = 1'b0;
    #1;
    chk("abort_phase", bus.phase, 0);
    chk("abort_rvalid", bus.cpu_rvalid, 0);
    idle();
    chk("abort_no_rvalid", bus.cpu_rvalid, 0);
    reset = 1'b1;
    idle();
    chk("post_abort_phase", bus.phase, 0);
    drive(0, 0, 0, 0, 0, 1, 100);
    idle();
    chk("ram_kept", bus.disp_rdata, 12'hABC);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
